slice_packer: RTL and testbench

SLICE_PACKER -- requirements
Module: slice_packer

---
 rtl/slice_packer.sv | 166 ++++++++++++++++
 tb/tb_slice_packer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slice_packer.sv
// -----------------------------------------------------------------------------
// slice_packer
//
// Packs a stream of 32-bit lane values into 96-bit words and writes them to a
// RAM of NUM_WORDS entries. Lanes fill in the order [31:0], [63:32], [95:64].
// A completed word, or a flushed partial word whose empty lanes hold PAD_VALUE,
// is written one cycle after the lane or flush that completes it.
//
// Handshake: a lane moves on a rising edge where in_valid & in_ready are both
// high. in_ready does not depend on in_valid. in_valid may be raised while
// in_ready is low. Such a lane is dropped, and after the first start it sets
// the sticky overflow flag.
//
// Ports
//   clk            single clock, rising edge
//   rst            asynchronous reset, active low
//   start          pulse: clear address and lane state, then begin a fill
//   in_valid       in_data is valid this cycle
//   in_data [31:0] lane value
//   in_ready       lanes are accepted this cycle
//   flush          pulse: write any partial word, padded
//   ram_address    RAM write address
//   ram_data       assembled 96-bit word
//   ram_wren       one-cycle write strobe
//   slice_state    next lane to fill (1..3), 0 when idle
//   words_written  words written since the last start
//   done           one-cycle pulse after the write to the last address
//   overflow       sticky, set when a lane arrives while not accepting
//   fsm_state      debug view of the control FSM (0 = IDLE, 1 = FILL)
// -----------------------------------------------------------------------------
module slice_packer #(
  parameter int unsigned NUM_WORDS = 2048,
  parameter logic [31:0] PAD_VALUE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  input  logic        flush,
  output logic [10:0] ram_address,
  output logic [95:0] ram_data,
  output logic        ram_wren,
  output logic [1:0]  slice_state,
  output logic [11:0] words_written,
  output logic        done,
  output logic        overflow,
  output logic        fsm_state
);

  localparam logic [10:0] LAST_ADDR  = 11'(NUM_WORDS - 1);
  localparam logic [11:0] WORD_LIMIT = 12'(NUM_WORDS);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  lane_q;
  logic [31:0] lane1_q, lane2_q;
  logic [10:0] addr_q;
  logic [11:0] count_q;
  logic [95:0] data_q;
  logic        wren_q, done_q, ovf_q, started_q;

  logic        write_ok, last_write, accept, write_now;
  logic [1:0]  filled;
  logic [31:0] w1, w2;
  logic [95:0] word_d;

  // Datapath decisions for the current cycle.
  always_comb begin
    // A start in the strobe cycle cancels the registered write.
    write_ok   = wren_q & ~start;
    last_write = write_ok & (addr_q == LAST_ADDR);
    // start wins over a lane presented in the same cycle.
    accept     = in_valid & in_ready & ~start;
    // Lanes holding data once this cycle's lane (if any) is taken.
    filled     = accept ? lane_q : (lane_q - 2'd1);
    write_now  = (state_q == S_FILL) & ~start & (count_q != WORD_LIMIT) &
                 ((filled == 2'd3) | (flush & (filled != 2'd0)));
    w1         = (accept && lane_q == 2'd1) ? in_data : lane1_q;
    w2         = (accept && lane_q == 2'd2) ? in_data : lane2_q;
    word_d     = {(filled == 2'd3) ? in_data : PAD_VALUE,
                  (filled >= 2'd2) ? w2      : PAD_VALUE,
                  (filled >= 2'd1) ? w1      : PAD_VALUE};
  end

  // FSM: state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // FSM: next state. FILL stays on through the final write strobe and
  // returns to IDLE together with the done pulse.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_FILL;
      S_FILL: begin
        if (start)           state_d = S_FILL;
        else if (last_write) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs. in_ready drops as soon as the last word has been queued.
  always_comb begin
    in_ready    = (state_q == S_FILL) && (count_q != WORD_LIMIT);
    slice_state = (state_q == S_FILL) ? lane_q : 2'd0;
    ram_wren    = write_ok;
    fsm_state   = state_q;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_q    <= 2'd1;
      lane1_q   <= '0;
      lane2_q   <= '0;
      addr_q    <= '0;
      count_q   <= '0;
      data_q    <= '0;
      wren_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      started_q <= 1'b0;
    end else if (start) begin
      lane_q    <= 2'd1;
      lane1_q   <= '0;
      lane2_q   <= '0;
      addr_q    <= '0;
      count_q   <= '0;
      wren_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      started_q <= 1'b1;
    end else begin
      wren_q <= write_now;
      done_q <= last_write;
      // The address holds at the last entry instead of wrapping.
      if (write_ok && addr_q != LAST_ADDR) addr_q <= addr_q + 11'd1;
      if (accept && lane_q == 2'd1) lane1_q <= in_data;
      if (accept && lane_q == 2'd2) lane2_q <= in_data;
      if (write_now) begin
        data_q  <= word_d;
        count_q <= count_q + 12'd1;
        lane_q  <= 2'd1;
      end else if (accept) begin
        lane_q  <= lane_q + 2'd1;
      end
      if (in_valid && !in_ready && started_q) ovf_q <= 1'b1;
    end
  end

  assign ram_address   = addr_q;
  assign ram_data      = data_q;
  assign words_written = count_q;
  assign done          = done_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_slice_packer.sv
module tb_slice_packer;

  localparam int unsigned NUM_WORDS = 4;
  localparam logic [31:0] PAD = 32'h0000_0000;
  localparam int W = 16 + 11 + 96;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0, in_valid = 1'b0, flush = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready, ram_wren, done, overflow, fsm_state;
  logic [10:0] ram_address;
  logic [95:0] ram_data;
  logic [1:0]  slice_state;
  logic [11:0] words_written;

  slice_packer #(.NUM_WORDS(NUM_WORDS), .PAD_VALUE(PAD)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .flush(flush),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .slice_state(slice_state), .words_written(words_written), .done(done),
    .overflow(overflow), .fsm_state(fsm_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // ---------------- reference model ----------------
  // Behavioural view: a list of accepted lanes, a count of queued words,
  // and the write that is due on the next cycle.
  logic [31:0] m_lanes[$];
  int          m_words = 0;
  bit          m_started = 0, m_fill = 0, m_ovf = 0, m_pend = 0;
  logic [10:0] m_pend_addr;
  logic [95:0] m_pend_data;

  // scoreboard queues: {cycle, addr, data} and done cycles
  logic [W-1:0] exp_q[$];
  logic [15:0]  exp_done_q[$];

  function automatic logic [10:0] m_addr();
    if (m_pend) return m_pend_addr;
    if (m_words >= NUM_WORDS) return 11'(NUM_WORDS - 1);
    return 11'(m_words);
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic s, input logic v, input logic [31:0] d, input logic f);
    logic [95:0] word;
    logic [15:0] c16;
    bit done_next;
    start = s; in_valid = v; in_data = d; flush = f;
    c16 = cyc[15:0];
    done_next = 0;
    if (m_pend && !s) begin
      exp_q.push_back({c16, m_pend_addr, m_pend_data});
      done_next = (int'(m_pend_addr) == NUM_WORDS - 1);
    end
    m_pend = 0;
    if (s) begin
      m_started = 1; m_fill = 1; m_lanes.delete(); m_words = 0; m_ovf = 0;
    end else begin
      if (v && m_fill && m_words < NUM_WORDS) m_lanes.push_back(d);
      else if (v && m_started) m_ovf = 1;
      if (m_fill && m_words < NUM_WORDS &&
          (m_lanes.size() == 3 || (f && m_lanes.size() > 0))) begin
        word = {PAD, PAD, PAD};
        for (int i = 0; i < m_lanes.size(); i++) word[32*i +: 32] = m_lanes[i];
        m_pend = 1; m_pend_addr = 11'(m_words); m_pend_data = word;
        m_words++; m_lanes.delete();
      end
    end
    @(posedge clk); #1;
    if (done_next) begin
      exp_done_q.push_back(c16 + 16'd1);
      m_fill = 0;
    end
    cyc++;
  endtask

  task automatic idle_cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [15:0] dc;
    if (ram_wren !== 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: cycle %0d addr %0d data %h, required no write", cyc, ram_address, ram_data);
      end else begin
        e = exp_q.pop_front();
        if ({cyc[15:0], ram_address, ram_data} !== e) begin
          errors++;
          $display("FAIL wr_compare: got cycle %0d addr %0d data %h, required cycle %0d addr %0d data %h",
                   cyc, ram_address, ram_data, e[W-1 -: 16], e[106:96], e[95:0]);
        end
      end
    end
    if (done !== 1'b0) begin
      checks++;
      if (exp_done_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: cycle %0d done %b, required 0", cyc, done);
      end else begin
        dc = exp_done_q.pop_front();
        if (cyc[15:0] !== dc) begin
          errors++;
          $display("FAIL done_cycle: got cycle %0d, required cycle %0d", cyc, dc);
        end
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, ram_wren, done, overflow, fsm_state} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b, required 00000", {in_ready, ram_wren, done, overflow, fsm_state});
    end
    checks++;
    if ({ram_address, words_written, slice_state} !== 25'd0) begin
      errors++; $display("FAIL reset_counters: addr %0d ww %0d slice %0d, required 0 0 0", ram_address, words_written, slice_state);
    end
    checks++;
    if (ram_data !== 96'd0) begin
      errors++; $display("FAIL reset_data: got %h, required 0", ram_data);
    end
    @(posedge clk); #1; cyc++;
    rst = 1'b1;
    // Lanes and flush before any start: ignored, no overflow.
    drive(1'b0, 1'b1, $urandom, 1'b1);
    drive(1'b0, 1'b1, $urandom, 1'b0);
    checks++;
    if ({overflow, in_ready, slice_state, fsm_state} !== 5'b0) begin
      errors++; $display("FAIL idle_before_start: ovf %b rdy %b slice %0d fsm %b, required all 0", overflow, in_ready, slice_state, fsm_state);
    end
  endtask

  task automatic test_basic();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    checks++;
    if ({in_ready, slice_state} !== 3'b101) begin
      errors++; $display("FAIL basic_start: rdy %b slice %0d, required 1 1", in_ready, slice_state);
    end
    drive(1'b0, 1'b1, 32'h11, 1'b0);
    drive(1'b0, 1'b1, 32'h22, 1'b0);
    drive(1'b0, 1'b1, 32'h33, 1'b0);
    checks++;
    if ({ram_wren, ram_address, ram_data, words_written} !==
        {1'b1, 11'd0, 96'h00000033_00000022_00000011, 12'd1}) begin
      errors++; $display("FAIL basic_write: wren %b addr %0d data %h ww %0d, required 1 0 00000033_00000022_00000011 1",
                         ram_wren, ram_address, ram_data, words_written);
    end
    idle_cycle();
    checks++;
    if (ram_address !== 11'd1 || exp_q.size() != 0) begin
      errors++; $display("FAIL basic_after: addr %0d pending %0d, required 1 0", ram_address, exp_q.size());
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 32'hA, 1'b0);
    drive(1'b0, 1'b1, 32'hB, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({ram_wren, ram_address, ram_data} !== {1'b1, 11'd0, 96'h00000000_0000000B_0000000A}) begin
      errors++; $display("FAIL flush_partial: wren %b addr %0d data %h, required 1 0 00000000_0000000B_0000000A", ram_wren, ram_address, ram_data);
    end
    checks++;
    if (slice_state !== 2'd1) begin
      errors++; $display("FAIL flush_lane_reset: got %0d, required 1", slice_state);
    end
    drive(1'b0, 1'b1, 32'hC, 1'b0);
    drive(1'b0, 1'b1, 32'hD, 1'b0);
    drive(1'b0, 1'b1, 32'hE, 1'b0);
    // Lane 3 together with flush: one write only.
    drive(1'b0, 1'b1, 32'hF, 1'b0);
    drive(1'b0, 1'b1, 32'h10, 1'b0);
    drive(1'b0, 1'b1, 32'h12, 1'b1);
    // Flush with nothing buffered: no write.
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    idle_cycle();
    checks++;
    if (exp_q.size() != 0 || words_written !== 12'd3) begin
      errors++; $display("FAIL flush_writes: pending %0d ww %0d, required 0 3", exp_q.size(), words_written);
    end
  endtask

  task automatic test_abort();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b1, $urandom, 1'b0);
    drive(1'b0, 1'b1, $urandom, 1'b0);
    drive(1'b1, 1'b1, $urandom, 1'b0);
    checks++;
    if ({ram_wren, slice_state, ram_address, overflow, words_written} !== {1'b0, 2'd1, 11'd0, 1'b0, 12'd0}) begin
      errors++; $display("FAIL abort_state: wren %b slice %0d addr %0d ovf %b ww %0d, required 0 1 0 0 0",
                         ram_wren, slice_state, ram_address, overflow, words_written);
    end
    drive(1'b0, 1'b1, 32'h1, 1'b0);
    drive(1'b0, 1'b1, 32'h2, 1'b0);
    drive(1'b0, 1'b1, 32'h3, 1'b0);
    // Start in the strobe cycle cancels the write.
    drive(1'b0, 1'b1, 32'h4, 1'b0);
    drive(1'b0, 1'b1, 32'h5, 1'b0);
    drive(1'b0, 1'b1, 32'h6, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    idle_cycle();
    checks++;
    if (exp_q.size() != 0 || words_written !== 12'd0 || ram_address !== 11'd0) begin
      errors++; $display("FAIL abort_cancel: pending %0d ww %0d addr %0d, required 0 0 0", exp_q.size(), words_written, ram_address);
    end
  endtask

  task automatic test_fill_to_end();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3 * NUM_WORDS; i++) drive(1'b0, 1'b1, $urandom, 1'b0);
    checks++;
    if (in_ready !== 1'b0 || ram_wren !== 1'b1 || ram_address !== 11'(NUM_WORDS - 1)) begin
      errors++; $display("FAIL end_ready: rdy %b wren %b addr %0d, required 0 1 %0d", in_ready, ram_wren, ram_address, NUM_WORDS - 1);
    end
    drive(1'b0, 1'b1, $urandom, 1'b0);
    checks++;
    if (overflow !== 1'b1 || done !== 1'b1 || fsm_state !== 1'b0) begin
      errors++; $display("FAIL end_overflow: ovf %b done %b fsm %b, required 1 1 0", overflow, done, fsm_state);
    end
    idle_cycle();
    idle_cycle();
    checks++;
    if (exp_q.size() != 0 || exp_done_q.size() != 0 || words_written !== 12'(NUM_WORDS) ||
        ram_address !== 11'(NUM_WORDS - 1) || slice_state !== 2'd0) begin
      errors++; $display("FAIL end_state: pend %0d done_pend %0d ww %0d addr %0d slice %0d, required 0 0 %0d %0d 0",
                         exp_q.size(), exp_done_q.size(), words_written, ram_address, slice_state, NUM_WORDS, NUM_WORDS - 1);
    end
  endtask

  task automatic test_random();
    logic s, v, f;
    logic [1:0] exp_slice;
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(0, 99) < 4);
      v = ($urandom_range(0, 99) < 75);
      f = ($urandom_range(0, 99) < 12);
      drive(s, v, $urandom, f);
      exp_slice = m_fill ? 2'(m_lanes.size() + 1) : 2'd0;
      checks++;
      if (in_ready !== (m_fill && m_words < NUM_WORDS) || slice_state !== exp_slice) begin
        errors++; $display("FAIL rand_ctrl @%0d: rdy %b slice %0d, required %b %0d", cyc, in_ready, slice_state,
                           (m_fill && m_words < NUM_WORDS), exp_slice);
      end
      checks++;
      if (words_written !== 12'(m_words) || overflow !== m_ovf || ram_address !== m_addr()) begin
        errors++; $display("FAIL rand_regs @%0d: ww %0d ovf %b addr %0d, required %0d %b %0d", cyc, words_written, overflow,
                           ram_address, m_words, m_ovf, m_addr());
      end
    end
    idle_cycle();
    idle_cycle();
    checks++;
    if (exp_q.size() != 0 || exp_done_q.size() != 0) begin
      errors++; $display("FAIL rand_drain: pending writes %0d done %0d, required 0 0", exp_q.size(), exp_done_q.size());
    end
  endtask

  task automatic test_reset_pending();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b1, $urandom, 1'b0);
    drive(1'b0, 1'b1, $urandom, 1'b0);
    drive(1'b0, 1'b1, $urandom, 1'b0);
    // Write strobe is due this cycle; reset kills it.
    rst = 1'b0;
    m_pend = 0; m_started = 0; m_fill = 0; m_ovf = 0; m_words = 0; m_lanes.delete();
    #1;
    checks++;
    if ({ram_wren, done, in_ready, overflow, fsm_state, ram_address, words_written, slice_state, ram_data} !== '0) begin
      errors++; $display("FAIL reset_pending: wren %b done %b rdy %b ovf %b addr %0d ww %0d slice %0d data %h, required all 0",
                         ram_wren, done, in_ready, overflow, ram_address, words_written, slice_state, ram_data);
    end
    @(posedge clk); #1; cyc++;
    rst = 1'b1;
    idle_cycle();
    idle_cycle();
    checks++;
    if (fsm_state !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL reset_stay_idle: fsm %b pending %0d, required 0 0", fsm_state, exp_q.size());
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_flush();
    test_abort();
    test_fill_to_end();
    test_random();
    test_reset_pending();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
